// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared opcodes, FSM state type, flag layout and opcode helpers
//               for the ALU issue/writeback controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam logic [5:0] OP_AND  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_ANDI = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    // Bit order matches the committed flags output: {C, Z, N, V}
    typedef struct packed {
        logic c;
        logic z;
        logic n;
        logic v;
    } flags_t;

    // Arithmetic ops are the only ones allowed to touch C and V
    function automatic logic is_arith(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op <= OP_ADDI;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : NUM_REGS x 32 register file, two combinational operand read
//               ports, one debug read port, one synchronous write port.
//               Entry 0 is never written, so it always reads as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int REG_AW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [31:0]       rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [31:0]       rdata_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    logic [31:0] r_mem [NUM_REGS];

    // Storage: cleared on reset; writes to entry 0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = r_mem[raddr_a];
    assign rdata_b  = r_mem[raddr_b];
    assign dbg_data = r_mem[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Serial issue/writeback controller for the combinational ALU.
//               Accepts one instruction, reads operands, presents them to the
//               ALU, captures the result and flags, then writes back and
//               commits the flags register. One instruction per 4 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int REG_AW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [5:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic [15:0]       instr_imm,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [5:0]        alu_opcode,
    input  logic [31:0]       alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_negative,
    input  logic              alu_overflow,
    output logic              done,
    output logic [31:0]       done_result,
    output logic              illegal,
    output logic [3:0]        flags,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    state_t            r_state;
    state_t            w_state_next;

    logic [5:0]        r_op;
    logic [REG_AW-1:0] r_rd;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [15:0]       r_imm;

    logic [31:0]       r_result;
    flags_t            r_alu_flags;
    flags_t            r_flags;

    logic              w_accept;
    logic              w_in_wb;
    logic              w_legal;
    logic              w_wr_en;
    logic [31:0]       w_rs1_data;
    logic [31:0]       w_rs2_data;

    alu_regfile #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (w_wr_en),
        .waddr    (r_rd),
        .wdata    (r_result),
        .raddr_a  (r_rs1),
        .rdata_a  (w_rs1_data),
        .raddr_b  (r_rs2),
        .rdata_b  (w_rs2_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: fixed walk IDLE -> READ -> EXEC -> WB -> IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (instr_valid) w_state_next = READ;
            READ:    w_state_next = EXEC;
            EXEC:    w_state_next = WB;
            WB:      w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs: handshake and writeback qualifiers
    always_comb begin
        instr_ready = (r_state == IDLE);
        w_accept    = (r_state == IDLE) && instr_valid;
        w_in_wb     = (r_state == WB);
        w_legal     = is_legal(r_op);
        w_wr_en     = w_in_wb && w_legal;
    end

    // Instruction fields are sampled only on the accept edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_rd  <= '0;
            r_rs1 <= '0;
            r_rs2 <= '0;
            r_imm <= '0;
        end else if (w_accept) begin
            r_op  <= instr_op;
            r_rd  <= instr_rd;
            r_rs1 <= instr_rs1;
            r_rs2 <= instr_rs2;
            r_imm <= instr_imm;
        end
    end

    // Operand launch: B is rs2, zero-extended imm (ANDI) or sign-extended imm (ADDI)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
        end else if (r_state == READ) begin
            alu_a      <= w_rs1_data;
            alu_opcode <= r_op;
            case (r_op)
                OP_ANDI: alu_b <= {16'h0000, r_imm};
                OP_ADDI: alu_b <= {{16{r_imm[15]}}, r_imm};
                default: alu_b <= w_rs2_data;
            endcase
        end
    end

    // Capture the settled ALU outputs at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_alu_flags <= '0;
        end else if (r_state == EXEC) begin
            r_result    <= alu_result;
            r_alu_flags <= '{c: alu_carry, z: alu_zero, n: alu_negative, v: alu_overflow};
        end
    end

    // Retire pulse: done for every instruction, result only for legal opcodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            illegal     <= 1'b0;
            done_result <= '0;
        end else begin
            done        <= w_in_wb;
            illegal     <= w_in_wb && !w_legal;
            done_result <= w_wr_en ? r_result : 32'h0;
        end
    end

    // Flag commit: Z/N on every legal op, C/V only on arithmetic ops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_wr_en) begin
            r_flags.z <= r_alu_flags.z;
            r_flags.n <= r_alu_flags.n;
            if (is_arith(r_op)) begin
                r_flags.c <= r_alu_flags.c;
                r_flags.v <= r_alu_flags.v;
            end
        end
    end

    assign flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl. Supplies a behavioural
//               ALU, runs directed and random instruction streams, and compares
//               against an architectural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  instr_op;
    logic [3:0]  instr_rd;
    logic [3:0]  instr_rs1;
    logic [3:0]  instr_rs2;
    logic [15:0] instr_imm;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_negative;
    logic        alu_overflow;
    logic        done;
    logic [31:0] done_result;
    logic        illegal;
    logic [3:0]  flags;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    int          n_vec;
    int          n_err;

    logic [31:0] m_regs [16];
    logic [3:0]  m_flags;
    logic [31:0] r_junk;

    alu_issue_ctrl #(
        .NUM_REGS (16),
        .REG_AW   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs1    (instr_rs1),
        .instr_rs2    (instr_rs2),
        .instr_imm    (instr_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .done         (done),
        .done_result  (done_result),
        .illegal      (illegal),
        .flags        (flags),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fresh garbage every cycle for the flags a logical op must ignore
    always @(posedge clk) r_junk <= $urandom;

    // Behavioural combinational ALU
    always_comb begin
        logic [32:0] w_sum;
        w_sum        = '0;
        alu_result   = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_opcode)
            6'd1, 6'd5: begin
                w_sum        = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = w_sum[31:0];
                alu_carry    = w_sum[32];
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            6'd2: begin
                alu_result   = alu_a - alu_b;
                alu_carry    = alu_a < alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            6'd0, 6'd4: begin
                alu_result   = alu_a & alu_b;
                alu_carry    = r_junk[0];
                alu_overflow = r_junk[1];
            end
            6'd3: begin
                alu_result   = alu_a | alu_b;
                alu_carry    = r_junk[2];
                alu_overflow = r_junk[3];
            end
            default: begin
                alu_result   = r_junk;
                alu_carry    = r_junk[4];
                alu_overflow = r_junk[5];
            end
        endcase
        alu_zero     = (alu_result == 32'h0);
        alu_negative = alu_result[31];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_flags = 4'h0;
    endtask

    // Architectural reference: rd = rs1 op operand, with flag rules
    task automatic model_exec(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                              input logic [3:0] rs2, input logic [15:0] imm,
                              output logic [31:0] res, output logic ill);
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] us;
        longint      ss;
        logic        c;
        logic        v;
        logic        arith;
        a     = m_regs[rs1];
        b     = m_regs[rs2];
        res   = 32'h0;
        ill   = 1'b0;
        arith = 1'b0;
        c     = m_flags[3];
        v     = m_flags[0];
        if (op == 6'd4) b = {16'h0, imm};
        if (op == 6'd5) b = {{16{imm[15]}}, imm};
        case (op)
            6'd0, 6'd4: res = a & b;
            6'd3:       res = a | b;
            6'd1, 6'd5: begin
                us    = {32'h0, a} + {32'h0, b};
                res   = us[31:0];
                c     = us > 64'hFFFF_FFFF;
                ss    = longint'($signed(a)) + longint'($signed(b));
                v     = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
                arith = 1'b1;
            end
            6'd2: begin
                res   = a - b;
                c     = b > a;
                ss    = longint'($signed(a)) - longint'($signed(b));
                v     = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
                arith = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (!ill) begin
            if (rd != 4'd0) m_regs[rd] = res;
            if (arith) m_flags = {c, (res == 32'h0), res[31], v};
            else       m_flags = {m_flags[3], (res == 32'h0), res[31], m_flags[0]};
        end
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            chk(tag, dbg_data, m_regs[i]);
        end
    endtask

    // Issue one instruction from a negedge, follow it to retirement
    task automatic run_instr(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                             input logic [3:0] rs2, input logic [15:0] imm);
        int          wait_cnt;
        logic [31:0] e_res;
        logic        e_ill;
        wait_cnt = 0;
        while (!instr_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("ready_before_issue", {31'h0, instr_ready}, 32'h1);
        instr_valid = 1'b1;
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        instr_imm   = imm;
        dbg_addr    = rd;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr_op    = 6'($urandom);
        instr_rd    = 4'($urandom);
        instr_rs1   = 4'($urandom);
        instr_rs2   = 4'($urandom);
        instr_imm   = 16'($urandom);
        model_exec(op, rd, rs1, rs2, imm, e_res, e_ill);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("done_timing", {31'h0, done}, {31'h0, (k == 4)});
            chk("ready_busy", {31'h0, instr_ready}, {31'h0, (k == 4)});
        end
        chk("illegal", {31'h0, illegal}, {31'h0, e_ill});
        chk("done_result", done_result, e_ill ? 32'h0 : e_res);
        chk("flags", {28'h0, flags}, {28'h0, m_flags});
        chk("rd_writeback", dbg_data, m_regs[rd]);
        @(negedge clk);
        chk("done_one_cycle", {31'h0, done}, 32'h0);
    endtask

    initial begin
        logic [3:0] f_snap;
        int         op_sel;
        logic [5:0] rop;
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = '0;
        instr_rd    = '0;
        instr_rs1   = '0;
        instr_rs2   = '0;
        instr_imm   = '0;
        dbg_addr    = '0;
        model_reset();

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("reset_done", {31'h0, done}, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_done", {31'h0, done}, 32'h0);
            chk("idle_ready", {31'h0, instr_ready}, 32'h1);
        end
        chk("reset_flags", {28'h0, flags}, 32'h0);
        chk("reset_alu_a", alu_a, 32'h0);
        chk("reset_alu_opcode", {26'h0, alu_opcode}, 32'h0);
        check_all_regs("reset_regs");

        // ADD with unsigned wrap to zero
        run_instr(6'd5, 4'd1, 4'd0, 4'd0, 16'hFFFF);
        run_instr(6'd5, 4'd2, 4'd0, 4'd0, 16'h0001);
        run_instr(6'd1, 4'd3, 4'd1, 4'd2, 16'h0);
        chk("add_r3", dbg_data, 32'h0);
        chk("add_flags", {28'h0, flags}, 32'hC);

        // Build 0x7FFFFFFF, then ADDI signed overflow
        run_instr(6'd5, 4'd10, 4'd0, 4'd0, 16'h0001);
        for (int i = 0; i < 31; i++) run_instr(6'd1, 4'd10, 4'd10, 4'd10, 16'h0);
        chk("build_r10", dbg_data, 32'h8000_0000);
        run_instr(6'd2, 4'd1, 4'd1, 4'd10, 16'h0);
        chk("build_r1", dbg_data, 32'h7FFF_FFFF);
        run_instr(6'd5, 4'd4, 4'd1, 4'd0, 16'h0001);
        chk("addi_r4", dbg_data, 32'h8000_0000);
        chk("addi_flags", {28'h0, flags}, 32'h3);
        run_instr(6'd5, 4'd5, 4'd0, 4'd0, 16'hFFFF);
        chk("addi_sext_r5", dbg_data, 32'hFFFF_FFFF);

        // SUB with borrow, then ANDI holds C/V
        run_instr(6'd5, 4'd3, 4'd0, 4'd0, 16'h0003);
        run_instr(6'd5, 4'd2, 4'd0, 4'd0, 16'h0005);
        run_instr(6'd2, 4'd6, 4'd3, 4'd2, 16'h0);
        chk("sub_r6", dbg_data, 32'hFFFF_FFFE);
        chk("sub_flags", {28'h0, flags}, 32'hA);
        run_instr(6'd4, 4'd7, 4'd6, 4'd0, 16'hFFFF);
        chk("andi_r7", dbg_data, 32'h0000_FFFE);
        chk("andi_flags", {28'h0, flags}, 32'h8);

        // Illegal opcode and r0 write discard
        f_snap = flags;
        run_instr(6'h2A, 4'd9, 4'd1, 4'd2, 16'h1234);
        chk("illegal_flags_hold", {28'h0, flags}, {28'h0, f_snap});
        check_all_regs("illegal_regs");
        run_instr(6'd1, 4'd0, 4'd1, 4'd1, 16'h0);
        chk("r0_zero", dbg_data, 32'h0);

        // Reset during EXEC aborts the instruction
        instr_valid = 1'b1;
        instr_op    = 6'd1;
        instr_rd    = 4'd8;
        instr_rs1   = 4'd1;
        instr_rs2   = 4'd1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_flags", {28'h0, flags}, 32'h0);
        @(negedge clk);
        chk("abort_done_hold", {31'h0, done}, 32'h0);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'h0, done}, 32'h0);
        end
        check_all_regs("abort_regs");
        run_instr(6'd5, 4'd8, 4'd0, 4'd0, 16'h0007);
        chk("after_abort_r8", dbg_data, 32'h7);

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            op_sel = int'($urandom_range(0, 7));
            rop    = (op_sel < 6) ? 6'(op_sel) : 6'($urandom_range(6, 63));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_instr(rop, 4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
            if ((n % 25) == 24) check_all_regs("random_regs");
        end
        check_all_regs("final_regs");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
